// File: rtl/hdmi_mode_pkg.sv
// Shared types for the HDMI mode switcher.
// Holds the FSM state, the counter widths and saturating increments.
package hdmi_mode_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BLANK,
    ST_RESET,
    ST_SETTLE
  } mode_state_e;

  localparam int FRAME_CNT_W = 8;
  localparam int CYCLE_CNT_W = 22;

  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
  typedef logic [FRAME_CNT_W:0]   frame_sum_t;
  typedef logic [CYCLE_CNT_W-1:0] cycle_cnt_t;

  function automatic cycle_cnt_t cyc_inc(
    input cycle_cnt_t v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic frame_cnt_t frm_inc(
    input frame_cnt_t v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mode_req_sync.sv
// Two-flop synchronizer for the video standard request.
// The output follows only after STABLE_CYCLES equal samples in a row.
module mode_req_sync
  import hdmi_mode_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024
) (
  input  logic clk_pixel,
  input  logic reset_n,
  input  logic async_in,
  output logic stable_out
);

  localparam cycle_cnt_t STABLE_C = cycle_cnt_t'(STABLE_CYCLES);

  logic       meta;
  logic       sync;
  logic       cand;
  cycle_cnt_t cnt;
  cycle_cnt_t cnt_inc;

  assign cnt_inc = cyc_inc(cnt);

  // cnt holds the run length of the current candidate, its first sample included
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      cand       <= 1'b0;
      cnt        <= '0;
      stable_out <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      if (sync != cand) begin
        cand <= sync;
        cnt  <= cycle_cnt_t'(1);
        if (STABLE_C <= cycle_cnt_t'(1))
          stable_out <= sync;
      end else begin
        if (cnt < STABLE_C)
          cnt <= cnt_inc;
        if (cnt_inc >= STABLE_C)
          stable_out <= cand;
      end
    end
  end

endmodule

// File: rtl/hdmi_mode_switcher.sv
// Sequences a PAL/NTSC change of the HDMI output stage:
// blank, reset the stage, let it settle muted, then resume.
module hdmi_mode_switcher
  import hdmi_mode_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int BLANK_FRAMES  = 1,
  parameter int RESET_CYCLES  = 64,
  parameter int SETTLE_FRAMES = 2,
  parameter int FRAME_TIMEOUT = 2000000
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        pal_mode_req,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic        pal_mode,
  output logic        hdmi_reset,
  output logic        video_blank,
  output logic        audio_enable,
  output logic        busy
);

  localparam cycle_cnt_t RESET_LAST = cycle_cnt_t'(RESET_CYCLES - 1);
  localparam cycle_cnt_t TO_LAST    = cycle_cnt_t'(FRAME_TIMEOUT - 1);
  localparam frame_sum_t BLANK_N    = frame_sum_t'(BLANK_FRAMES);
  localparam frame_sum_t SETTLE_N   = frame_sum_t'(SETTLE_FRAMES);

  mode_state_e state;
  mode_state_e state_nx;

  logic       req_stable;
  logic       target;
  logic       origin;
  logic       origin_q;
  logic       frame_start;
  logic       wait_st;
  logic       tick;
  logic       frames_done;
  frame_cnt_t frame_cnt;
  frame_sum_t frames_seen;
  cycle_cnt_t to_cnt;
  cycle_cnt_t rst_cnt;

  mode_req_sync #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .async_in  (pal_mode_req),
    .stable_out(req_stable)
  );

  assign origin      = (cx == '0) && (cy == '0);
  assign wait_st     = (state == ST_BLANK) || (state == ST_SETTLE);
  // a missing frame start is treated as if one had arrived
  assign tick        = frame_start || (to_cnt >= TO_LAST);
  assign frames_seen = frame_sum_t'(frame_cnt) + 1'b1;

  always_comb begin
    state_nx    = state;
    frames_done = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (req_stable != pal_mode)
          state_nx = ST_BLANK;
      end
      ST_BLANK: begin
        if (tick && (frames_seen >= BLANK_N)) begin
          state_nx    = ST_RESET;
          frames_done = 1'b1;
        end
      end
      ST_RESET: begin
        if (rst_cnt >= RESET_LAST)
          state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tick && (frames_seen >= SETTLE_N)) begin
          state_nx    = ST_RUN;
          frames_done = 1'b1;
        end
      end
      default: state_nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RESET;
      target       <= 1'b0;
      pal_mode     <= 1'b0;
      hdmi_reset   <= 1'b1;
      video_blank  <= 1'b1;
      audio_enable <= 1'b0;
      busy         <= 1'b1;
      origin_q     <= 1'b0;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
      to_cnt       <= '0;
      rst_cnt      <= '0;
    end else begin
      state        <= state_nx;
      origin_q     <= origin;
      frame_start  <= origin && !origin_q;
      hdmi_reset   <= (state_nx == ST_RESET);
      video_blank  <= (state_nx != ST_RUN);
      audio_enable <= (state_nx == ST_RUN);
      busy         <= (state_nx != ST_RUN);
      if ((state == ST_RUN) && (state_nx == ST_BLANK))
        target <= req_stable;
      if ((state == ST_BLANK) && (state_nx == ST_RESET))
        pal_mode <= target;
      if ((state == ST_RESET) && (state_nx == ST_RESET))
        rst_cnt <= cyc_inc(rst_cnt);
      else
        rst_cnt <= '0;
      if (wait_st && !tick)
        to_cnt <= cyc_inc(to_cnt);
      else
        to_cnt <= '0;
      if (!wait_st || frames_done)
        frame_cnt <= '0;
      else if (tick)
        frame_cnt <= frm_inc(frame_cnt);
    end
  end

endmodule

// File: tb/tb_hdmi_mode_switcher.sv
// Randomized bench for hdmi_mode_switcher against a
// countdown-based behavioural model, plus directed timing checks.
module tb_hdmi_mode_switcher;

  localparam int STABLE  = 4;
  localparam int BLANK_F = 1;
  localparam int RST_CYC = 16;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [10:0] cx = '0;
  logic [9:0]  cy = '0;
  logic        pal_mode;
  logic        hdmi_reset;
  logic        video_blank;
  logic        audio_enable;
  logic        busy;

  int  checks = 0;
  int  errors = 0;
  bit  hold = 1'b0;
  bit  jump = 1'b0;

  always #5 clk = ~clk;

  hdmi_mode_switcher #(
    .STABLE_CYCLES(STABLE),
    .BLANK_FRAMES (BLANK_F),
    .RESET_CYCLES (RST_CYC),
    .SETTLE_FRAMES(SETTLE),
    .FRAME_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_pixel   (clk),
    .reset_n     (rst_n),
    .pal_mode_req(req),
    .cx          (cx),
    .cy          (cy),
    .pal_mode    (pal_mode),
    .hdmi_reset  (hdmi_reset),
    .video_blank (video_blank),
    .audio_enable(audio_enable),
    .busy        (busy)
  );

  // 858x525 raster, optionally frozen or jumped to the last pixel
  initial begin
    forever begin
      @(negedge clk);
      if (hold) begin
        cx = 11'd5;
        cy = 10'd5;
      end else if (jump && $urandom_range(0, 199) == 0) begin
        cx = 11'd857;
        cy = 10'd524;
      end else if (cx == 11'd857) begin
        cx = '0;
        cy = (cy == 10'd524) ? '0 : cy + 10'd1;
      end else begin
        cx = cx + 11'd1;
      end
    end
  end

  // model: phase 0 idle, 1 blanking, 2 resetting, 3 settling
  int m_ph;
  bit m_pal, m_tgt, m_stable, m_fs, m_prev_org;
  int frames_left, cycles_left, wait_left;
  bit pipe_q[$];
  bit samp_q[$];

  task automatic m_reset();
    m_ph = 2;
    m_pal = 0;
    m_tgt = 0;
    m_stable = 0;
    m_fs = 0;
    m_prev_org = 0;
    cycles_left = RST_CYC;
    pipe_q = '{1'b0, 1'b0};
    samp_q.delete();
  endtask

  task automatic m_step();
    bit ev, org, s, same;
    case (m_ph)
      0: if (m_stable != m_pal) begin
        m_ph = 1;
        m_tgt = m_stable;
        frames_left = BLANK_F;
        wait_left = TIMEOUT;
      end
      1, 3: begin
        wait_left--;
        ev = m_fs || (wait_left == 0);
        if (ev) begin
          frames_left--;
          wait_left = TIMEOUT;
          if (frames_left == 0) begin
            if (m_ph == 1) begin
              m_ph = 2;
              m_pal = m_tgt;
              cycles_left = RST_CYC;
            end else begin
              m_ph = 0;
            end
          end
        end
      end
      default: begin
        cycles_left--;
        if (cycles_left == 0) begin
          m_ph = 3;
          frames_left = SETTLE;
          wait_left = TIMEOUT;
        end
      end
    endcase
    s = pipe_q.pop_front();
    pipe_q.push_back(req);
    samp_q.push_back(s);
    if (samp_q.size() > STABLE) void'(samp_q.pop_front());
    if (samp_q.size() == STABLE) begin
      same = 1;
      foreach (samp_q[i]) if (samp_q[i] != s) same = 0;
      if (same) m_stable = s;
    end
    org = (cx == 0) && (cy == 0);
    m_fs = org && !m_prev_org;
    m_prev_org = org;
  endtask

  initial begin
    logic [4:0] got, exp;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
      #1;
      got = {pal_mode, hdmi_reset, video_blank, audio_enable, busy};
      exp = {m_pal, m_ph == 2, m_ph != 0, m_ph == 0, m_ph != 0};
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors < 30)
          $display("FAIL model t=%0t got %b want %b (pal,rst,blank,aud,busy)",
                   $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return busy;
      1: return hdmi_reset;
      2: return video_blank;
      default: return audio_enable;
    endcase
  endfunction

  task automatic wait_lvl(input string nm, input int sel,
                          input logic lvl, input int bound);
    int n;
    n = 0;
    while (sig(sel) !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sig(sel) !== lvl) begin
      errors++;
      $display("FAIL %s timeout got %b want %b", nm, sig(sel), lvl);
    end
  endtask

  task automatic count_rst(output int n);
    n = 0;
    while (hdmi_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {pal_mode, hdmi_reset, video_blank, audio_enable, busy},
        5'b01101);
  endtask

  initial begin
    int n;
    repeat (5) @(negedge clk);
    chk_reset_vals("reset_vals");
    rst_n = 1'b1;
    count_rst(n);
    chk("poweron_rst_len", n, 16);
    wait_lvl("poweron_unblank", 2, 1'b0, 3000);
    chk("poweron_pal", pal_mode, 0);

    req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += busy + hdmi_reset + pal_mode;
    end
    chk("glitch_ignored", n, 0);

    req = 1'b1;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_latency", n, 7);
    wait_lvl("pal_rst_rise", 1, 1'b1, 3000);
    chk("pal_on_rst", pal_mode, 1);
    wait_lvl("pal_rst_fall", 1, 1'b0, 100);
    wait_lvl("pal_audio", 3, 1'b1, 3000);

    hold = 1'b1;
    req = 1'b0;
    wait_lvl("to_busy", 0, 1'b1, 50);
    n = 0;
    while (!hdmi_reset && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("blank_timeout", n, 1000);
    hold = 1'b0;
    wait_lvl("to_done", 0, 1'b0, 3000);
    chk("to_pal", pal_mode, 0);

    req = 1'b1;
    wait_lvl("sw_rst_rise", 1, 1'b1, 3000);
    wait_lvl("sw_rst_fall", 1, 1'b0, 100);
    repeat (5) @(negedge clk);
    req = 1'b0;
    wait_lvl("sw_done", 0, 1'b0, 3000);
    chk("sw_pal1", pal_mode, 1);
    @(negedge clk);
    chk("resw_busy", busy, 1);
    wait_lvl("resw_done", 0, 1'b0, 4000);
    chk("resw_pal0", pal_mode, 0);

    req = 1'b1;
    wait_lvl("abort_rst_rise", 1, 1'b1, 3000);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort_vals");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_rst(n);
    chk("abort_rst_len", n, 16);
    wait_lvl("abort_run", 0, 1'b0, 3000);
    chk("abort_pal", pal_mode, 0);
    @(negedge clk);
    chk("abort_follow", busy, 1);
    wait_lvl("abort_pal_done", 0, 1'b0, 4000);
    chk("abort_pal1", pal_mode, 1);

    jump = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(1, 150)) @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        req = ~req;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        req = ~req;
      end else begin
        req = 1'($urandom_range(0, 1));
      end
    end
    jump = 1'b0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
